host_key_decoder: RTL

// - Turns the PS/2 set-2 scancode byte stream into held-key levels left/right/jump.
// - One instance per player drives that player's movement controller.
// - Sits between the PS/2 byte receiver (upstream) and the movement controller (downstream).
// - Tracks the make/break (F0) and extended (E0) prefixes; each output stays high from make to break.

---
 rtl/host_key_decoder_if.sv | 20 ++
 rtl/host_key_decoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/host_key_decoder_if.sv
// Scancode byte stream in, held-key levels and framing-error pulse out.
// master = byte receiver / movement-controller side; slave = the decoder.
interface host_key_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       left;
  logic       right;
  logic       jump;
  logic       frame_err;

  modport master (
    output rx_data, rx_valid,
    input  left, right, jump, frame_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output left, right, jump, frame_err
  );
endinterface

// File: rtl/host_key_decoder.sv
// PS/2 set-2 scancode decoder: tracks E0/F0 prefixes and holds left/right/jump from make to break.
// Optional feature: define KEY_STUCK_RELEASE_EN to force-release keys after a long idle bus.
module host_key_decoder #(
  parameter logic [7:0]  KEY_LEFT     = 8'h6B,
  parameter logic [7:0]  KEY_RIGHT    = 8'h74,
  parameter logic [7:0]  KEY_JUMP     = 8'h75,
  parameter bit          EXT_KEYS     = 1'b1,
  parameter int unsigned PREFIX_TMO   = 65_000,
  parameter int unsigned STUCK_CYCLES = 65_000_000
) (
  input logic               clk,
  input logic               rst_n,
  host_key_decoder_if.slave bus
);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam int TMO_W = $clog2(PREFIX_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREFIX_TMO - 1);

  if (PREFIX_TMO < 2 || STUCK_CYCLES < 2) begin : g_cfg_check
    $error("host_key_decoder: PREFIX_TMO and STUCK_CYCLES must both be at least 2");
  end

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state, state_nx;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nx;
  logic             left_q, right_q, jump_q, err_q;
  logic             left_nx, right_nx, jump_nx, err_nx;
  logic             is_make, is_break, key_ext, key_hit;
  logic             is_prefix;
  logic             any_held;
  logic             stuck_fire;

  assign is_prefix = (bus.rx_data == CODE_EXT) || (bus.rx_data == CODE_BRK);
  assign any_held  = left_q | right_q | jump_q;

`ifdef KEY_STUCK_RELEASE_EN
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYCLES - 1);

  logic [STK_W-1:0] stuck_cnt;

  assign stuck_fire = !bus.rx_valid && any_held && (stuck_cnt >= STK_LAST);

  // Once released nothing is held, so the counter parks at zero until traffic resumes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stuck_cnt <= '0;
    end else if (bus.rx_valid || !any_held || stuck_fire) begin
      stuck_cnt <= '0;
    end else begin
      stuck_cnt <= stuck_cnt + STK_W'(1);
    end
  end
`else
  assign stuck_fire = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    tmo_cnt_nx = tmo_cnt;
    err_nx     = 1'b0;
    is_make    = 1'b0;
    is_break   = 1'b0;
    key_ext    = 1'b0;

    // A byte always wins over a prefix timeout firing in the same cycle.
    if (bus.rx_valid) begin
      tmo_cnt_nx = '0;
      unique case (state)
        IDLE: begin
          if (bus.rx_data == CODE_EXT)      state_nx = EXT;
          else if (bus.rx_data == CODE_BRK) state_nx = BRK;
          else                              is_make  = 1'b1;
        end
        EXT: begin
          if (bus.rx_data == CODE_BRK) begin
            state_nx = EXT_BRK;
          end else if (bus.rx_data != CODE_EXT) begin
            is_make  = 1'b1;
            key_ext  = 1'b1;
            state_nx = IDLE;
          end
        end
        BRK: begin
          state_nx = IDLE;
          if (is_prefix) err_nx   = 1'b1;
          else           is_break = 1'b1;
        end
        EXT_BRK: begin
          state_nx = IDLE;
          key_ext  = 1'b1;
          if (is_prefix) err_nx   = 1'b1;
          else           is_break = 1'b1;
        end
      endcase
    end else if (state == IDLE) begin
      tmo_cnt_nx = '0;
    end else if (tmo_cnt >= TMO_LAST) begin
      state_nx   = IDLE;
      err_nx     = 1'b1;
      tmo_cnt_nx = '0;
    end else begin
      tmo_cnt_nx = tmo_cnt + TMO_W'(1);
    end
  end

  assign key_hit = (is_make || is_break) && (key_ext == EXT_KEYS);

  always_comb begin
    left_nx  = left_q;
    right_nx = right_q;
    jump_nx  = jump_q;
    if (stuck_fire) begin
      left_nx  = 1'b0;
      right_nx = 1'b0;
      jump_nx  = 1'b0;
    end else if (key_hit) begin
      if (bus.rx_data == KEY_LEFT)  left_nx  = is_make;
      if (bus.rx_data == KEY_RIGHT) right_nx = is_make;
      if (bus.rx_data == KEY_JUMP)  jump_nx  = is_make;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      jump_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= tmo_cnt_nx;
      left_q  <= left_nx;
      right_q <= right_nx;
      jump_q  <= jump_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.left      = left_q;
  assign bus.right     = right_q;
  assign bus.jump      = jump_q;
  assign bus.frame_err = err_q;

endmodule
